msg_packer: RTL

Byte-to-word packer that sits directly upstream of the circular DMA's S_AXIS input. Measurement cores emit messages as 8-bit AXI-Stream beats terminated by `tlast`. This block packs those bytes little-endian into `C_AXIS_WIDTH`-bit words, zero-pads the final word of each message, and forwards `tlast` on that word. The DMA therefore always receives whole, word-aligned messages.

---
 rtl/msg_packer.sv | 86 ++++++++
 1 files changed

// File: rtl/msg_packer.sv
// Byte-to-word AXI-Stream packer: little-endian, zero-padded final word, tlast forwarded.
// Optional MSG_PACKER_STATS_EN adds a 32-bit msg_count of emitted messages.
module msg_packer #(
  parameter int C_AXIS_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
`ifdef MSG_PACKER_STATS_EN
  ,
  output logic [31:0]             msg_count
`endif
);

  localparam int N  = C_AXIS_WIDTH / 8;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [C_AXIS_WIDTH-1:0] acc;
  logic [C_AXIS_WIDTH-1:0] word;
  logic [IW-1:0]           idx;
  logic                    completing;
  logic                    out_free;
  logic                    accept;

  assign completing    = (idx == LAST_IDX) || s_axis_tlast;
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = rst_n && (!completing || out_free);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Lanes below idx come from acc, lane idx takes the incoming byte, lanes above are zero.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      localparam logic [IW-1:0] LANE = IW'(gi);
      assign word[8*gi +: 8] = (LANE < idx)  ? acc[8*gi +: 8] :
                               (LANE == idx) ? s_axis_tdata   : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      if (completing) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= word;
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept && completing) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= word;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef MSG_PACKER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      msg_count <= msg_count + 32'd1;
    end
  end
`endif

endmodule
